ecc_op_sequencer: RTL and testbench
===================================

Name: ecc_op_sequencer

Overview:
- APB-slave control block that owns the ECC encoder/decoder core: holds its configuration/data registers, launches one operation per CTRL write, waits for core completion and publishes results.
- Drives the operation_done / num_of_errors / data_out / prdata signals the verification checker samples.
- Sits between the APB bus and the ECC core; the core itself is not part of this block.

Parameters:
- AMBA_WORD, 32, APB data bus width.
- AMBA_ADDR_WIDTH, 20, APB address width; only paddr[4:0] decoded.
- DATA_WIDTH, 32, core data/codeword width.
- TIMEOUT, 64, max cycles in WAIT before forced completion; must be >= 2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- psel  in  1  APB select.
- penable  in  1  APB access phase.
- pwrite  in  1  APB write (1) / read (0).
- paddr  in  AMBA_ADDR_WIDTH  register address.
- pwdata  in  AMBA_WORD  write data.
- prdata  out  AMBA_WORD  read data.
- core_start  out  1  one-cycle launch pulse to core.
- core_mode  out  2  00 encode, 01 decode, 10 full channel.
- core_width  out  2  codeword width select.
- core_data_in  out  DATA_WIDTH  operand to core.
- core_done  in  1  core completion pulse.
- core_data_out  in  DATA_WIDTH  core result.
- core_num_err  in  2  core error count (0, 1, 2).
- operation_done  out  1  one-cycle completion pulse.
- num_of_errors  out  2  latched error count; 3 = timeout.
- data_out  out  DATA_WIDTH  latched result.
- busy  out  1  high in LAUNCH/WAIT/DONE.

Behaviour:
- Reset: all outputs 0, all registers 0, FSM in IDLE, timeout counter 0.
- Register map (offset, bits):
  - 0x00 CTRL: mode[1:0] in bits [1:0]; any write starts an operation.
  - 0x04 DATA_IN: full width.
  - 0x08 WIDTH: bits [1:0].
  - 0x10 STATUS (RO): bit0 busy, bits[2:1] num_of_errors, bit3 overrun (sticky).
  - 0x14 DATA_OUT (RO).
  - Undefined offsets read 0.
- APB: zero-wait-state, no pready.
  - Writes commit on the edge where psel & penable & pwrite.
  - prdata is registered on the setup edge (psel & !penable & !pwrite), so it is valid for the whole access phase and one cycle after.
  - prdata holds its value otherwise.
- FSM:
  - IDLE: a CTRL write latches the mode, then the state goes to LAUNCH.
  - LAUNCH: core_start=1 for exactly this cycle; core_mode, core_width and core_data_in are driven from the registers (held stable from LAUNCH through DONE); then WAIT.
  - WAIT: counter increments each cycle.
    - On core_done: latch core_data_out→data_out and core_num_err→num_of_errors, then DONE.
    - Else, at counter==TIMEOUT-1: num_of_errors=3, data_out unchanged, then DONE.
  - DONE: operation_done=1 for exactly this cycle; counter cleared; then IDLE.
- Latency: CTRL write edge → core_start 1 cycle later; core_done edge → operation_done 1 cycle later.
- Any write to CTRL, DATA_IN or WIDTH while busy is ignored (registers frozen) and sets overrun. Overrun clears only on rst.
- core_done in the same cycle as the timeout terminal count: done wins, normal result latched.
- core_done outside WAIT: ignored.
- rst asserted mid-operation: immediate return to IDLE next edge, core_start/operation_done deasserted, no result latched.
- data_out/num_of_errors hold until the next completion.

Optional Feature:
- Macro: ECC_OP_SEQUENCER_IRQ_EN.
- Defined:
  - Adds output port irq (1 bit) and CTRL bit 2 irq_en.
  - irq is sticky; it sets in DONE when irq_en=1.
  - It clears on an APB write to STATUS with pwdata[0]=1 (STATUS becomes write-1-to-clear for that bit only).
  - rst clears irq and irq_en.
- Undefined: no irq port; CTRL bit 2 is ignored and reads 0; STATUS writes are ignored.

Decomposition:
- Package ecc_op_pkg holds:
  - the FSM state enum (IDLE, LAUNCH, WAIT, DONE);
  - register offset constants;
  - mode encodings;
  - NUM_ERR_TIMEOUT=2'd3.
- Sub-module ecc_op_regs holds the APB decode, register bank and prdata mux; the top holds the FSM, counter and result latches.

Test Plan:
- Reset, then read STATUS and DATA_OUT → prdata=0 both; all outputs 0.
- Write DATA_IN=0xA5A5_0F0F, WIDTH=2, CTRL=0 → core_start pulse 1 cycle after CTRL write; core_mode=00, core_data_in=0xA5A50F0F.
  - Model responds core_done 5 cycles later with core_data_out=0x1234_5678, num_err=0.
  - Response: operation_done 1 cycle later, data_out=0x12345678, STATUS read=0x0.
- Decode with core_num_err=2 → num_of_errors=2, STATUS[2:1]=2.
- Core never responds → operation_done at cycle TIMEOUT+1 after launch, num_of_errors=3.
- CTRL write during WAIT → no second core_start; STATUS bit3=1; DATA_IN unchanged on read back.
- rst pulse during WAIT, then core_done → no operation_done, busy=0; IRQ build: irq set after a completion with irq_en=1, cleared by STATUS write 0x1.

Source files
------------

// File: rtl/ecc_op_pkg.sv
// Shared constants for the ECC operation sequencer: FSM states, register map, mode codes.
package ecc_op_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LAUNCH = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [4:0] OFF_CTRL     = 5'h00;
    localparam logic [4:0] OFF_DATA_IN  = 5'h04;
    localparam logic [4:0] OFF_WIDTH    = 5'h08;
    localparam logic [4:0] OFF_STATUS   = 5'h10;
    localparam logic [4:0] OFF_DATA_OUT = 5'h14;

    localparam logic [1:0] MODE_ENCODE = 2'b00;
    localparam logic [1:0] MODE_DECODE = 2'b01;
    localparam logic [1:0] MODE_FULL   = 2'b10;

    localparam logic [1:0] NUM_ERR_TIMEOUT = 2'd3;

endpackage

// File: rtl/ecc_op_sequencer_if.sv
// Zero-wait-state APB bus (no pready) between host and the ECC operation sequencer.
interface ecc_op_sequencer_if #(
    parameter int unsigned AMBA_WORD       = 32,
    parameter int unsigned AMBA_ADDR_WIDTH = 20
);
    logic                       psel;
    logic                       penable;
    logic                       pwrite;
    logic [AMBA_ADDR_WIDTH-1:0] paddr;
    logic [AMBA_WORD-1:0]       pwdata;
    logic [AMBA_WORD-1:0]       prdata;

    modport master (output psel, penable, pwrite, paddr, pwdata, input prdata);
    modport slave  (input psel, penable, pwrite, paddr, pwdata, output prdata);
endinterface

// File: rtl/ecc_op_regs.sv
// APB decode, configuration register bank and registered read mux for the sequencer.
// ECC_OP_SEQUENCER_IRQ_EN adds CTRL.irq_en and the STATUS write-1-to-clear strobe.
module ecc_op_regs
    import ecc_op_pkg::*;
#(
    parameter int unsigned AMBA_WORD       = 32,
    parameter int unsigned AMBA_ADDR_WIDTH = 20,
    parameter int unsigned DATA_WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    ecc_op_sequencer_if.slave     apb,
    input  logic                  busy,
    input  logic [1:0]            num_of_errors,
    input  logic [DATA_WIDTH-1:0] data_out,
    output logic                  start_c,
    output logic [1:0]            mode,
    output logic [1:0]            width,
    output logic [DATA_WIDTH-1:0] data_in,
`ifdef ECC_OP_SEQUENCER_IRQ_EN
    output logic                  irq_en,
    output logic                  irq_clr_c,
`endif
    output logic                  overrun
);

    logic [4:0]           addr;
    logic                 wr_c;
    logic                 rd_setup_c;
    logic                 cfg_hit_c;
    logic [AMBA_WORD-1:0] rdata_c;
    logic                 unused_addr_c;

    assign addr          = apb.paddr[4:0];
    assign unused_addr_c = ^apb.paddr[AMBA_ADDR_WIDTH-1:5];
    assign wr_c          = apb.psel & apb.penable & apb.pwrite;
    assign rd_setup_c    = apb.psel & ~apb.penable & ~apb.pwrite;
    assign cfg_hit_c     = (addr == OFF_CTRL) || (addr == OFF_DATA_IN) || (addr == OFF_WIDTH);
    assign start_c       = wr_c && (addr == OFF_CTRL) && !busy;
`ifdef ECC_OP_SEQUENCER_IRQ_EN
    assign irq_clr_c     = wr_c && (addr == OFF_STATUS) && apb.pwdata[0];
`endif

    // Read mux; unmapped offsets return zero
    always_comb begin
        rdata_c = '0;
        case (addr)
`ifdef ECC_OP_SEQUENCER_IRQ_EN
            OFF_CTRL:     rdata_c = AMBA_WORD'({irq_en, mode});
`else
            OFF_CTRL:     rdata_c = AMBA_WORD'(mode);
`endif
            OFF_DATA_IN:  rdata_c = AMBA_WORD'(data_in);
            OFF_WIDTH:    rdata_c = AMBA_WORD'(width);
            OFF_STATUS:   rdata_c = AMBA_WORD'({overrun, num_of_errors, busy});
            OFF_DATA_OUT: rdata_c = AMBA_WORD'(data_out);
            default:      rdata_c = '0;
        endcase
    end

    // Configuration is frozen while an operation is in flight; attempts flag overrun
    always_ff @(posedge clk) begin
        if (rst) begin
            mode       <= '0;
            width      <= '0;
            data_in    <= '0;
            overrun    <= 1'b0;
            apb.prdata <= '0;
`ifdef ECC_OP_SEQUENCER_IRQ_EN
            irq_en     <= 1'b0;
`endif
        end else begin
            if (wr_c && !busy) begin
                case (addr)
                    OFF_CTRL: begin
                        mode <= apb.pwdata[1:0];
`ifdef ECC_OP_SEQUENCER_IRQ_EN
                        irq_en <= apb.pwdata[2];
`endif
                    end
                    OFF_DATA_IN: data_in <= DATA_WIDTH'(apb.pwdata);
                    OFF_WIDTH:   width   <= apb.pwdata[1:0];
                    default:     ;
                endcase
            end
            if (wr_c && busy && cfg_hit_c) begin
                overrun <= 1'b1;
            end
            if (rd_setup_c) begin
                apb.prdata <= rdata_c;
            end
        end
    end

endmodule

// File: rtl/ecc_op_sequencer.sv
// APB-controlled launcher for the ECC core: one operation per CTRL write, timeout-guarded.
// ECC_OP_SEQUENCER_IRQ_EN adds a sticky completion interrupt output (irq).
module ecc_op_sequencer
    import ecc_op_pkg::*;
#(
    parameter int unsigned AMBA_WORD       = 32,
    parameter int unsigned AMBA_ADDR_WIDTH = 20,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned TIMEOUT         = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    ecc_op_sequencer_if.slave     apb,
    output logic                  core_start,
    output logic [1:0]            core_mode,
    output logic [1:0]            core_width,
    output logic [DATA_WIDTH-1:0] core_data_in,
    input  logic                  core_done,
    input  logic [DATA_WIDTH-1:0] core_data_out,
    input  logic [1:0]            core_num_err,
    output logic                  operation_done,
    output logic [1:0]            num_of_errors,
    output logic [DATA_WIDTH-1:0] data_out,
`ifdef ECC_OP_SEQUENCER_IRQ_EN
    output logic                  irq,
`endif
    output logic                  busy
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             start_c;
    logic             latch_c;
    logic             timeout_c;
    logic             overrun;
`ifdef ECC_OP_SEQUENCER_IRQ_EN
    logic             irq_en;
    logic             irq_clr_c;
`endif

    ecc_op_regs #(
        .AMBA_WORD       (AMBA_WORD),
        .AMBA_ADDR_WIDTH (AMBA_ADDR_WIDTH),
        .DATA_WIDTH      (DATA_WIDTH)
    ) u_regs (
        .clk           (clk),
        .rst           (rst),
        .apb           (apb),
        .busy          (busy),
        .num_of_errors (num_of_errors),
        .data_out      (data_out),
        .start_c       (start_c),
        .mode          (core_mode),
        .width         (core_width),
        .data_in       (core_data_in),
`ifdef ECC_OP_SEQUENCER_IRQ_EN
        .irq_en        (irq_en),
        .irq_clr_c     (irq_clr_c),
`endif
        .overrun       (overrun)
    );

    // Next-state, counter and result-capture decisions
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        latch_c   = 1'b0;
        timeout_c = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_nxt = '0;
                if (start_c) state_nxt = ST_LAUNCH;
            end
            ST_LAUNCH: begin
                cnt_nxt   = '0;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_nxt = cnt + CNT_W'(1);
                // A done pulse on the terminal count still counts as a normal result
                if (core_done) begin
                    latch_c   = 1'b1;
                    state_nxt = ST_DONE;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    timeout_c = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                cnt_nxt   = '0;
                state_nxt = ST_IDLE;
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            core_start     <= 1'b0;
            operation_done <= 1'b0;
            busy           <= 1'b0;
            num_of_errors  <= '0;
            data_out       <= '0;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            core_start     <= (state_nxt == ST_LAUNCH);
            operation_done <= (state_nxt == ST_DONE);
            busy           <= (state_nxt != ST_IDLE);
            if (latch_c) begin
                data_out      <= core_data_out;
                num_of_errors <= core_num_err;
            end else if (timeout_c) begin
                num_of_errors <= NUM_ERR_TIMEOUT;
            end
        end
    end

`ifdef ECC_OP_SEQUENCER_IRQ_EN
    // Sticky completion interrupt; a completion in the same cycle as a clear wins
    always_ff @(posedge clk) begin
        if (rst) begin
            irq <= 1'b0;
        end else if ((state_nxt == ST_DONE) && irq_en) begin
            irq <= 1'b1;
        end else if (irq_clr_c) begin
            irq <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_ecc_op_sequencer.sv
// Self-checking bench for ecc_op_sequencer: vector table of complete operations plus
// hand-written overrun, CTRL bit 2, interrupt and mid-operation reset sequences.
module tb_ecc_op_sequencer;

    localparam int unsigned TIMEOUT = 16;

    localparam logic [19:0] A_CTRL     = 20'h00;
    localparam logic [19:0] A_DATA_IN  = 20'h04;
    localparam logic [19:0] A_WIDTH    = 20'h08;
    localparam logic [19:0] A_STATUS   = 20'h10;
    localparam logic [19:0] A_DATA_OUT = 20'h14;

    typedef struct {
        logic [1:0]  mode;
        logic [31:0] din;
        logic [1:0]  width;
        int          delay;      // negedge after launch at which core_done pulses; 0 = never
        logic [31:0] rsp;
        logic [1:0]  rsp_err;
        int          exp_cyc;    // cycles from launch to operation_done
        logic [31:0] exp_dout;
        logic [1:0]  exp_nerr;
        logic [31:0] exp_status;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        core_start;
    logic [1:0]  core_mode;
    logic [1:0]  core_width;
    logic [31:0] core_data_in;
    logic        core_done;
    logic [31:0] core_data_out;
    logic [1:0]  core_num_err;
    logic        operation_done;
    logic [1:0]  num_of_errors;
    logic [31:0] data_out;
    logic        busy;
`ifdef ECC_OP_SEQUENCER_IRQ_EN
    logic        irq;
`endif

    int n_chk;
    int n_pass;
    int start_cnt;

    ecc_op_sequencer_if #(.AMBA_WORD(32), .AMBA_ADDR_WIDTH(20)) apb_bus ();

    ecc_op_sequencer #(
        .AMBA_WORD(32), .AMBA_ADDR_WIDTH(20), .DATA_WIDTH(32), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .apb            (apb_bus.slave),
        .core_start     (core_start),
        .core_mode      (core_mode),
        .core_width     (core_width),
        .core_data_in   (core_data_in),
        .core_done      (core_done),
        .core_data_out  (core_data_out),
        .core_num_err   (core_num_err),
        .operation_done (operation_done),
        .num_of_errors  (num_of_errors),
        .data_out       (data_out),
`ifdef ECC_OP_SEQUENCER_IRQ_EN
        .irq            (irq),
`endif
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (core_start) start_cnt++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic apb_write(input logic [19:0] a, input logic [31:0] d);
        @(negedge clk);
        apb_bus.psel = 1'b1; apb_bus.penable = 1'b0; apb_bus.pwrite = 1'b1;
        apb_bus.paddr = a;   apb_bus.pwdata = d;
        @(negedge clk);
        apb_bus.penable = 1'b1;
        @(negedge clk);
        apb_bus.psel = 1'b0; apb_bus.penable = 1'b0; apb_bus.pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [19:0] a, output logic [31:0] d);
        @(negedge clk);
        apb_bus.psel = 1'b1; apb_bus.penable = 1'b0; apb_bus.pwrite = 1'b0;
        apb_bus.paddr = a;
        @(negedge clk);
        apb_bus.penable = 1'b1;
        d = apb_bus.prdata;
        @(negedge clk);
        apb_bus.psel = 1'b0; apb_bus.penable = 1'b0;
    endtask

    // From the launch negedge, drive the core response and return cycles to operation_done
    task automatic run_core(input int delay, input logic [31:0] rsp, input logic [1:0] err,
                            output int op_cyc);
        op_cyc = 0;
        for (int k = 1; k <= int'(TIMEOUT) + 8; k++) begin
            @(negedge clk);
            if (operation_done) begin
                op_cyc    = k;
                core_done = 1'b0;
                break;
            end
            core_done     = (k == delay);
            core_data_out = rsp;
            core_num_err  = err;
        end
        core_done = 1'b0;
    endtask

    vec_t        vecs[5];
    logic [31:0] rd;
    int          cyc;
    int          s0;
    logic        od_seen;

    initial begin
        n_chk = 0; n_pass = 0; start_cnt = 0;
        rst = 1'b1;
        core_done = 1'b0; core_data_out = '0; core_num_err = '0;
        apb_bus.psel = 1'b0; apb_bus.penable = 1'b0; apb_bus.pwrite = 1'b0;
        apb_bus.paddr = '0; apb_bus.pwdata = '0;

        vecs[0] = '{2'b00, 32'hA5A5_0F0F, 2'd2, 5,       32'h1234_5678, 2'd0, 6,           32'h1234_5678, 2'd0, 32'h0};
        vecs[1] = '{2'b01, 32'h0000_FFFF, 2'd1, 3,       32'hCAFE_BABE, 2'd2, 4,           32'hCAFE_BABE, 2'd2, 32'h4};
        vecs[2] = '{2'b10, 32'h1357_9BDF, 2'd3, 0,       32'h0,         2'd0, TIMEOUT + 1, 32'hCAFE_BABE, 2'd3, 32'h6};
        vecs[3] = '{2'b01, 32'h2468_ACE0, 2'd0, 1,       32'h0F0F_0F0F, 2'd1, 2,           32'h0F0F_0F0F, 2'd1, 32'h2};
        vecs[4] = '{2'b00, 32'hFFFF_0000, 2'd2, TIMEOUT, 32'h89AB_CDEF, 2'd0, TIMEOUT + 1, 32'h89AB_CDEF, 2'd0, 32'h0};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_op_done", 32'(operation_done), 32'h0);
        check("reset_core_start", 32'(core_start), 32'h0);
        check("reset_data_out", data_out, 32'h0);
        check("reset_nerr", 32'(num_of_errors), 32'h0);
        apb_read(A_STATUS, rd);   check("reset_status_rd", rd, 32'h0);
        apb_read(A_DATA_OUT, rd); check("reset_dataout_rd", rd, 32'h0);

        foreach (vecs[i]) begin
            apb_write(A_DATA_IN, vecs[i].din);
            apb_write(A_WIDTH, 32'(vecs[i].width));
            s0 = start_cnt;
            apb_write(A_CTRL, 32'(vecs[i].mode));
            check($sformatf("v%0d_core_start", i), 32'(core_start), 32'h1);
            check($sformatf("v%0d_core_mode", i), 32'(core_mode), 32'(vecs[i].mode));
            check($sformatf("v%0d_core_width", i), 32'(core_width), 32'(vecs[i].width));
            check($sformatf("v%0d_core_din", i), core_data_in, vecs[i].din);
            run_core(vecs[i].delay, vecs[i].rsp, vecs[i].rsp_err, cyc);
            check($sformatf("v%0d_latency", i), 32'(cyc), 32'(vecs[i].exp_cyc));
            check($sformatf("v%0d_data_out", i), data_out, vecs[i].exp_dout);
            check($sformatf("v%0d_nerr", i), 32'(num_of_errors), 32'(vecs[i].exp_nerr));
            @(negedge clk);
            check($sformatf("v%0d_op_done_pulse", i), 32'(operation_done), 32'h0);
            check($sformatf("v%0d_busy_after", i), 32'(busy), 32'h0);
            check($sformatf("v%0d_one_start", i), 32'(start_cnt - s0), 32'h1);
            apb_read(A_STATUS, rd);   check($sformatf("v%0d_status_rd", i), rd, vecs[i].exp_status);
            apb_read(A_DATA_OUT, rd); check($sformatf("v%0d_dataout_rd", i), rd, vecs[i].exp_dout);
        end

        // CTRL bit 2 is irq_en only in the interrupt build
        apb_write(A_CTRL, 32'h5);
        run_core(2, 32'hDEAD_0001, 2'd1, cyc);
        check("irqen_latency", 32'(cyc), 32'h3);
        @(negedge clk);
        apb_read(A_CTRL, rd);
`ifdef ECC_OP_SEQUENCER_IRQ_EN
        check("ctrl_rd_irq_en", rd, 32'h5);
        check("irq_set", 32'(irq), 32'h1);
        apb_write(A_STATUS, 32'h1);
        check("irq_cleared", 32'(irq), 32'h0);
`else
        check("ctrl_rd_no_irq", rd, 32'h1);
        apb_write(A_STATUS, 32'h1);
`endif

        // Writes while busy are dropped and flag a sticky overrun
        apb_write(A_DATA_IN, 32'h1111_1111);
        s0 = start_cnt;
        apb_write(A_CTRL, 32'h0);
        apb_write(A_CTRL, 32'h1);
        apb_write(A_DATA_IN, 32'h2222_2222);
        apb_read(A_STATUS, rd);
        check("ovr_status_busy", rd, 32'hB);
        check("ovr_mode_held", 32'(core_mode), 32'h0);
        check("ovr_din_held", core_data_in, 32'h1111_1111);
        core_done = 1'b1; core_data_out = 32'h5555_AAAA; core_num_err = 2'd0;
        @(negedge clk);
        core_done = 1'b0;
        check("ovr_op_done", 32'(operation_done), 32'h1);
        @(negedge clk);
        check("ovr_one_start", 32'(start_cnt - s0), 32'h1);
        apb_read(A_DATA_IN, rd); check("ovr_din_rd", rd, 32'h1111_1111);
        apb_read(A_STATUS, rd);  check("ovr_status_idle", rd, 32'h8);

        // Reset during WAIT abandons the operation; a late core_done is ignored
        apb_write(A_CTRL, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        core_done = 1'b1; core_data_out = 32'h7777_7777; core_num_err = 2'd2;
        @(negedge clk);
        core_done = 1'b0;
        od_seen = operation_done;
        repeat (3) begin
            @(negedge clk);
            od_seen = od_seen | operation_done | core_start;
        end
        check("rst_no_op_done", 32'(od_seen), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_data_out", data_out, 32'h0);
        check("rst_nerr", 32'(num_of_errors), 32'h0);
        apb_read(A_STATUS, rd); check("rst_status_rd", rd, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
